serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
Bit-serial transmitter that drives the serial two's-complement datapath. It accepts parallel words over a valid/ready handshake and emits each word LSB-first, one bit per clock. A word-start marker is asserted on the first bit of every word so the downstream serial stage clears its carry state. A one-entry holding register lets words stream back-to-back with no idle cycles.

Parameters:
WIDTH, 12, bits per word (minimum 2).
GAP, 0, idle cycles inserted after each word (0 = back-to-back streaming allowed).

Ports:
t_clk  input  1  clock; all state updates on rising edge.
r  input  1  reset, synchronous, active-high.
in_data  input  WIDTH  parallel word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word; equals NOT hold_full.
i_out  output  1  serial data bit, LSB first.
r_out  output  1  word-start marker, high only during bit 0 of each word.
word_done  output  1  high only during the bit WIDTH-1 cycle of each word.
busy  output  1  high in SHIFT or GAP state.

Behaviour:
- Reset (r=1 at an edge): state=IDLE; hold empty; bit count=0; i_out=0, r_out=0, word_done=0, busy=0; in_ready=1 after that edge. Reset mid-word aborts the word and discards the held word; no partial bits follow.
- Accept: at an edge with in_valid=1 and in_ready=1, in_data is written to the hold register (hold_full=1). in_ready is driven combinationally from the registered hold_full.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE: if hold_full, then at the next edge move hold into the shift register, clear hold, set bit count=0 and enter SHIFT. Outputs become i_out=word[0], r_out=1.
- Latency: word accepted at edge k from IDLE -> bit 0 on i_out after edge k+1. Bit n is visible after edge k+1+n.
- SHIFT: each edge advances one bit. r_out=0 for bits 1..WIDTH-1. word_done=1 while bit WIDTH-1 is on i_out.
- End of word, at the edge that ends bit WIDTH-1:
  - GAP>0: enter GAP; i_out=0, r_out=0 for exactly GAP cycles, then go to IDLE handling (load immediately if hold_full).
  - GAP=0 and hold_full: load the next word on this same edge; next cycle shows the new bit 0 with r_out=1 (no bubble).
  - GAP=0 and hold empty: enter IDLE; i_out=0, r_out=0.
- Hold transfer and a new accept cannot coincide on the same edge, because in_ready=0 while hold is full. The hold refills from the edge after the transfer.
- Outside SHIFT, i_out=0, r_out=0 and word_done=0.
- busy=1 in SHIFT and GAP; busy=0 in IDLE.
- Back-to-back throughput (GAP=0): one word every WIDTH cycles, sustained with in_valid held high.
- Held data is not modified by changes on in_data after acceptance.

Test Plan:
- Reset, then accept 12'hA5C once -> from the next cycle i_out = 0,0,1,1,1,0,1,0,0,1,0,1. r_out=1 on the first bit only. word_done=1 on the 12th bit. Then IDLE with i_out=0, busy=0.
- GAP=0, in_valid held with 12'h001 then 12'hFFF -> 24 contiguous bits: 1 followed by eleven 0s, then twelve 1s. r_out high at bit cycles 0 and 12. No idle cycle between words. in_ready drops while hold is full.
- Backpressure: offer three words during the first word's transmission -> second is accepted into hold, third sees in_ready=0 until the second moves to shift. All three are emitted in order, with no loss or duplication.
- GAP=2, two queued words 12'h800, 12'h7FF -> exactly two cycles with i_out=0, r_out=0 and busy=1 between words. The second r_out pulse falls 14 cycles after the first.
- Reset asserted at bit 5 of 12'hFFF with a held word pending -> next cycle i_out=0, r_out=0, busy=0, in_ready=1. Neither word resumes. A fresh word after reset transmits normally.
- Loop-back check: serial_word_tx feeding the serial complementer with words 12'h001, 12'h000, 12'h800 -> serial outputs equal 12'hFFF, 12'h000, 12'h800 (LSB first).

Source files
------------

// File: rtl/serial_word_tx.sv
// Bit-serial word transmitter: parallel words in over valid/ready, LSB-first
// serial bits out with a word-start marker, optional idle gap between words.
module serial_word_tx #(
  parameter int WIDTH = 12,
  parameter int GAP   = 0
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             i_out,
  output logic             r_out,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             i_out_q, i_out_d;
  logic             r_out_q, r_out_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             load;

  assign in_ready  = ~hold_full_q;
  assign i_out     = i_out_q;
  assign r_out     = r_out_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

  // cnt_q is the index of the bit currently driven on i_out
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gap_cnt_d   = gap_cnt_q;
    i_out_d     = 1'b0;
    r_out_d     = 1'b0;
    word_done_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      S_SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d       = cnt_q + CW'(1);
          i_out_d     = shift_q[0];
          shift_d     = shift_q >> 1;
          word_done_d = (cnt_q == CW'(WIDTH - 2));
        end
      end
      S_GAP: begin
        if (int'(gap_cnt_q) >= GAP - 1) begin
          if (hold_full_q) load = 1'b1;
          else             state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading puts bit 0 on the wire immediately, so the shifter keeps the rest
    if (load) begin
      state_d     = S_SHIFT;
      shift_d     = hold_q >> 1;
      i_out_d     = hold_q[0];
      r_out_d     = 1'b1;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end

    // Accept only while hold is empty, so it never coincides with a load
    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge t_clk) begin
    if (r) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      i_out_q     <= 1'b0;
      r_out_q     <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      i_out_q     <= i_out_d;
      r_out_q     <= r_out_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
    end
  end

  // Data registers carry no reset; hold_full_q/state_q qualify their contents
  always_ff @(posedge t_clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a GAP=0 and a GAP=2 instance, a
// scoreboard of sent words, and a serial two's-complement negator model.
module tb_serial_word_tx;

  logic        clk;
  logic        rr   [2];
  logic [11:0] dd   [2];
  logic        vv   [2];
  logic        rdy  [2];
  logic        io   [2];
  logic        ro   [2];
  logic        wd   [2];
  logic        bz   [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];

  int          bitn      [2];
  logic [11:0] acc       [2];
  logic [11:0] nacc      [2];
  logic        seen      [2];
  int          start_cyc [2];
  int          prev_start[2];

  serial_word_tx #(.WIDTH(12), .GAP(0)) dut0 (
    .t_clk(clk), .r(rr[0]), .in_data(dd[0]), .in_valid(vv[0]),
    .in_ready(rdy[0]), .i_out(io[0]), .r_out(ro[0]), .word_done(wd[0]), .busy(bz[0])
  );

  serial_word_tx #(.WIDTH(12), .GAP(2)) dut2 (
    .t_clk(clk), .r(rr[1]), .in_data(dd[1]), .in_valid(vv[1]),
    .in_ready(rdy[1]), .i_out(io[1]), .r_out(ro[1]), .word_done(wd[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flush(input int d);
    bitn[d] = -1;
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic finish_word(input int d);
    logic [11:0] e;
    logic        have;
    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
    chk("word_without_expect", {31'd0, have}, 32'd1);
    if (have) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk("serial_word", {20'd0, acc[d]}, {20'd0, e});
      chk("loopback_negated", {20'd0, nacc[d]}, {20'd0, 12'(~e + 12'd1)});
    end
    bitn[d] = -1;
  endtask

  // Deserialise one output cycle; the negator passes bits through the first 1
  // and inverts the rest, restarting on every word-start marker.
  task automatic mon(input int d);
    if (ro[d]) begin
      chk("r_out_only_at_bit0", bitn[d], 32'hFFFF_FFFF);
      bitn[d]       = 0;
      prev_start[d] = start_cyc[d];
      start_cyc[d]  = cyc;
      seen[d]       = 1'b0;
      acc[d]        = '0;
      nacc[d]       = '0;
    end else if (bitn[d] >= 0) begin
      bitn[d]++;
    end
    if (bitn[d] < 0) begin
      chk("idle_i_out", {31'd0, io[d]}, 32'd0);
      chk("idle_word_done", {31'd0, wd[d]}, 32'd0);
    end else begin
      acc[d][bitn[d]]  = io[d];
      nacc[d][bitn[d]] = seen[d] ? ~io[d] : io[d];
      seen[d]          = seen[d] | io[d];
      chk("word_done_pos", {31'd0, wd[d]}, {31'd0, (bitn[d] == 11)});
      chk("busy_in_word", {31'd0, bz[d]}, 32'd1);
      if (bitn[d] == 11) finish_word(d);
    end
  endtask

  task automatic step();
    logic rs0, rs1;
    rs0 = rr[0];
    rs1 = rr[1];
    @(posedge clk);
    #1;
    cyc++;
    if (rs0) flush(0); else mon(0);
    if (rs1) flush(1); else mon(1);
  endtask

  task automatic send(input int d, input logic [11:0] w, output int waited);
    logic ok;
    ok     = 1'b0;
    waited = 0;
    dd[d]  = w;
    vv[d]  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rdy[d]) begin
        if (d == 0) q0.push_back(w);
        else        q1.push_back(w);
        step();
        ok = 1'b1;
        break;
      end
      waited++;
      step();
    end
    vv[d] = 1'b0;
    dd[d] = ~w;
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    if (ok) chk("in_ready_low_when_held", {31'd0, rdy[d]}, 32'd0);
  endtask

  task automatic drain(input int d);
    int qs;
    for (int i = 0; i < 80; i++) begin
      qs = (d == 0) ? q0.size() : q1.size();
      if (!bz[d] && qs == 0 && bitn[d] < 0) break;
      step();
    end
    qs = (d == 0) ? q0.size() : q1.size();
    chk("drain_queue_empty", qs, 32'd0);
    chk("drain_busy_low", {31'd0, bz[d]}, 32'd0);
    chk("drain_i_out_low", {31'd0, io[d]}, 32'd0);
  endtask

  initial begin
    int w;
    int w3;
    for (int d = 0; d < 2; d++) begin
      rr[d] = 1'b1; vv[d] = 1'b0; dd[d] = '0;
      bitn[d] = -1; start_cyc[d] = 0; prev_start[d] = 0;
      acc[d] = '0; nacc[d] = '0; seen[d] = 1'b0;
    end
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_i_out", {31'd0, io[d]}, 32'd0);
      chk("reset_r_out", {31'd0, ro[d]}, 32'd0);
      chk("reset_word_done", {31'd0, wd[d]}, 32'd0);
      chk("reset_busy", {31'd0, bz[d]}, 32'd0);
      chk("reset_in_ready", {31'd0, rdy[d]}, 32'd1);
      rr[d] = 1'b0;
    end
    step();

    // Single word, then return to idle
    send(0, 12'hA5C, w);
    chk("first_bit_latency", {31'd0, ro[0]}, 32'd0);
    step();
    chk("first_bit_r_out", {31'd0, ro[0]}, 32'd1);
    chk("first_bit_value", {31'd0, io[0]}, 32'd0);
    drain(0);

    // Back-to-back streaming with valid held
    send(0, 12'h001, w);
    send(0, 12'hFFF, w);
    drain(0);
    chk("b2b_marker_spacing", start_cyc[0] - prev_start[0], 32'd12);

    // Backpressure: third word must wait for the hold register to drain
    send(0, 12'h1A1, w);
    send(0, 12'h2B2, w);
    send(0, 12'h3C3, w3);
    chk("bp_third_word_waited", {31'd0, (w3 > 5)}, 32'd1);
    drain(0);

    // Idle gap between queued words
    send(1, 12'h800, w);
    send(1, 12'h7FF, w);
    for (int i = 0; i < 30; i++) begin
      if (wd[1]) break;
      step();
    end
    chk("gap_first_word_done", {31'd0, wd[1]}, 32'd1);
    for (int g = 0; g < 2; g++) begin
      step();
      chk("gap_i_out", {31'd0, io[1]}, 32'd0);
      chk("gap_r_out", {31'd0, ro[1]}, 32'd0);
      chk("gap_busy", {31'd0, bz[1]}, 32'd1);
    end
    step();
    chk("gap_second_start", {31'd0, ro[1]}, 32'd1);
    drain(1);
    chk("gap_marker_spacing", start_cyc[1] - prev_start[1], 32'd14);

    // Reset mid-word with a held word pending
    send(0, 12'hFFF, w);
    send(0, 12'h123, w);
    for (int i = 0; i < 30; i++) begin
      if (bitn[0] == 5) break;
      step();
    end
    chk("reached_bit5", bitn[0], 32'd5);
    rr[0] = 1'b1;
    step();
    rr[0] = 1'b0;
    chk("midrst_i_out", {31'd0, io[0]}, 32'd0);
    chk("midrst_r_out", {31'd0, ro[0]}, 32'd0);
    chk("midrst_busy", {31'd0, bz[0]}, 32'd0);
    chk("midrst_in_ready", {31'd0, rdy[0]}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_resume", {31'd0, ro[0] | bz[0]}, 32'd0);
    end
    send(0, 12'h3C5, w);
    drain(0);

    // Loop-back through the serial negator
    send(0, 12'h001, w);
    send(0, 12'h000, w);
    send(0, 12'h800, w);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
